gray_sync_decode: RTL and testbench

// - Downstream consumer of the 4-bit binary-to-Gray encoder. Samples a Gray-coded value
//   (e.g. a counter/pointer from another domain) into the local clock, synchronises it,

---
 rtl/gray_pkg.sv | 25 ++
 rtl/gray_sync_decode_sync_chain.sv | 29 ++
 rtl/gray_sync_decode.sv | 65 ++++++
 tb/tb_gray_sync_decode.sv | 124 ++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Gray/binary conversion helpers shared by the encoder side, this decoder and the bench.
// Functions work on a GRAY_MAXW-bit container; unused upper bits must be zero.
package gray_pkg;

  localparam int GRAY_MAXW = 32;

  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
    logic [GRAY_MAXW-1:0] b;
    b = g;
    for (int s = 1; s < GRAY_MAXW; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

  function automatic logic onehot0_or_zero(input logic [GRAY_MAXW-1:0] x);
    return ((x & (x - GRAY_MAXW'(1))) == '0);
  endfunction

endpackage

// File: rtl/gray_sync_decode_sync_chain.sv
// Synchronous-reset flop chain used to bring an asynchronous Gray bus into the clk domain.
module sync_chain #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_sync_decode.sv
// Synchronises a Gray-coded bus, decodes it to binary and reports each change with
// its modular step size and a flag for illegal multi-bit transitions.
module gray_sync_decode
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] gray_sync,
  output logic [WIDTH-1:0] bin_out,
  output logic             upd,
  output logic [WIDTH-1:0] step,
  output logic             err
);

  logic [WIDTH-1:0] grayPrev_q;
  logic [WIDTH-1:0] binOut_q;
  logic [WIDTH-1:0] step_q;
  logic             upd_q;
  logic             err_q;

  logic [WIDTH-1:0] bin_d;
  logic             multiBit_d;

  sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gray_in),
    .q   (gray_sync)
  );

  always_comb begin
    bin_d      = WIDTH'(gray2bin(GRAY_MAXW'(gray_sync)));
    multiBit_d = !onehot0_or_zero(GRAY_MAXW'(gray_sync ^ grayPrev_q));
  end

  // An illegal jump still updates bin_out; err only flags it alongside upd.
  always_ff @(posedge clk) begin
    if (rst) begin
      grayPrev_q <= '0;
      binOut_q   <= '0;
      step_q     <= '0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      grayPrev_q <= gray_sync;
      binOut_q   <= bin_d;
      step_q     <= bin_d - binOut_q;
      upd_q      <= (gray_sync != grayPrev_q);
      err_q      <= multiBit_d;
    end
  end

  assign bin_out = binOut_q;
  assign step    = step_q;
  assign upd     = upd_q;
  assign err     = err_q;

endmodule

// File: tb/tb_gray_sync_decode.sv
// Directed bench for gray_sync_decode: stimulus pushes expected updates into a queue,
// a negedge monitor pops and compares each time the DUT pulses upd.
module tb_gray_sync_decode;

  typedef struct packed {
    logic [3:0] bin;
    logic [3:0] step;
    logic       err;
  } expT;

  logic       clk;
  logic       rst;
  logic [3:0] gray_in;
  logic [3:0] gray_sync;
  logic [3:0] bin_out;
  logic       upd;
  logic [3:0] step;
  logic       err;

  expT expQ[$];
  int  vecCount;
  int  missCount;

  gray_sync_decode #(
    .WIDTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .gray_sync (gray_sync),
    .bin_out   (bin_out),
    .upd       (upd),
    .step      (step),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %b, want %b", name, actual, expected);
    end
  endtask

  // Drive a Gray value, optionally queue the update it should cause, then hold it.
  task automatic applyStimulus(input logic [3:0] g, input bit expectUpd, input expT e, input int holdCycles);
    gray_in = g;
    if (expectUpd) expQ.push_back(e);
    repeat (holdCycles) @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag, input logic [3:0] expBin);
    checkOutput({tag, " upd idle"}, {3'b0, upd}, 4'b0000);
    checkOutput({tag, " err idle"}, {3'b0, err}, 4'b0000);
    checkOutput({tag, " bin hold"}, bin_out, expBin);
  endtask

  always @(negedge clk) begin
    if (upd === 1'b1) begin
      if (expQ.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL unexpected upd: got bin=%b step=%b err=%b, want no update", bin_out, step, err);
      end else begin
        expT e;
        e = expQ.pop_front();
        checkOutput("upd bin_out", bin_out, e.bin);
        checkOutput("upd step", step, e.step);
        checkOutput("upd err", {3'b0, err}, {3'b0, e.err});
      end
    end
  end

  initial begin
    vecCount  = 0;
    missCount = 0;
    rst       = 1'b1;
    gray_in   = 4'b1100;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset bin_out", bin_out, 4'b0000);
    checkOutput("reset gray_sync", gray_sync, 4'b0000);
    checkOutput("reset step", step, 4'b0000);
    checkOutput("reset upd", {3'b0, upd}, 4'b0000);
    checkOutput("reset err", {3'b0, err}, 4'b0000);

    rst = 1'b0;
    applyStimulus(4'b1100, 1'b1, '{bin: 4'b1000, step: 4'b1000, err: 1'b1}, 6);
    checkIdle("first", 4'b1000);
    applyStimulus(4'b1101, 1'b1, '{bin: 4'b1001, step: 4'b0001, err: 1'b0}, 6);
    checkIdle("legal", 4'b1001);
    applyStimulus(4'b1110, 1'b1, '{bin: 4'b1011, step: 4'b0010, err: 1'b1}, 6);
    checkIdle("illegal", 4'b1011);
    applyStimulus(4'b1000, 1'b1, '{bin: 4'b1111, step: 4'b0100, err: 1'b1}, 6);
    checkIdle("to max", 4'b1111);
    applyStimulus(4'b0000, 1'b1, '{bin: 4'b0000, step: 4'b0001, err: 1'b0}, 6);
    checkIdle("wrap", 4'b0000);
    applyStimulus(4'b0100, 1'b1, '{bin: 4'b0111, step: 4'b0111, err: 1'b0}, 6);
    checkIdle("pre-reset", 4'b0111);

    // The new value sits only in the first sync stage when rst hits.
    applyStimulus(4'b0101, 1'b0, '{bin: 4'b0000, step: 4'b0000, err: 1'b0}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst bin_out", bin_out, 4'b0000);
    checkOutput("midrst gray_sync", gray_sync, 4'b0000);
    checkOutput("midrst upd", {3'b0, upd}, 4'b0000);
    checkOutput("midrst err", {3'b0, err}, 4'b0000);
    applyStimulus(4'b0101, 1'b1, '{bin: 4'b0110, step: 4'b0110, err: 1'b1}, 6);
    checkIdle("post-reset", 4'b0110);

    checkOutput("pending updates", 4'(expQ.size()), 4'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
